// File: rtl/csp1_tensor_loader.sv
// Packs a serial fp16 word stream into the flat CSP1_1 x tensor, pulses csp_reset, waits SETTLE_CYCLES, then flags result_valid.
// Latency: result_valid rises SETTLE_CYCLES+1 cycles after the final accepted word; words pass through bit-exact.
// Backpressure: s_ready is low outside FILL, so no word is accepted while settling or while a result is held.
module csp1_tensor_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int D             = 3,
    parameter int H             = 4,
    parameter int W             = 4,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_last,
    output logic [D*H*W*DATA_WIDTH-1:0]    x,
    output logic                           csp_reset,
    output logic                           result_valid,
    input  logic                           release_req,
    output logic                           len_err
);

    localparam int              N           = D * H * W;
    localparam int              IW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   LAST_IDX    = IW'(N - 1);
    localparam logic [15:0]     SETTLE_LOAD = 16'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [N*DATA_WIDTH-1:0] x_q, x_d;
    logic                    len_err_q, len_err_d;
    logic                    first_q, first_d;
    logic                    live_q;
    logic                    hs;
    logic                    tensor_end;

    assign hs         = s_valid & s_ready;
    assign tensor_end = hs & (s_last | (idx_q == LAST_IDX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (tensor_end) state_d = SETTLE;
            SETTLE:  if (!first_q && cnt_q <= 16'd1) state_d = HOLD;
            HOLD:    if (release_req) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // live_q holds s_ready low and csp_reset high for the first cycle out of reset.
    always_comb begin
        s_ready      = (state_q == FILL) & live_q;
        csp_reset    = ~live_q | ((state_q == SETTLE) & first_q);
        result_valid = (state_q == HOLD);
    end

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        len_err_d = len_err_q;
        first_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (hs) begin
                    x_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = s_data;
                    if (tensor_end) begin
                        idx_d   = '0;
                        cnt_d   = SETTLE_LOAD;
                        first_d = 1'b1;
                        // Short tensors and unmarked full tensors are both length errors.
                        if (s_last != (idx_q == LAST_IDX)) len_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (!first_q) cnt_d = (cnt_q <= 16'd1) ? 16'd0 : cnt_q - 16'd1;
            end
            HOLD: begin
                if (release_req) x_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            len_err_q <= 1'b0;
            first_q   <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            len_err_q <= len_err_d;
            first_q   <= first_d;
            live_q    <= 1'b1;
        end
    end

    assign x       = x_q;
    assign len_err = len_err_q;

endmodule
